// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
// Shared constants and configuration helpers for the segmented pipelined adder.
//   DEF_WIDTH / DEF_SEG_W : default operand width and segment width
//   calc_nseg()           : number of pipeline stages for a WIDTH/SEG_W pair
//   seg_cfg_ok()          : legality check used at elaboration time
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SEG_W = 8;

   function automatic int calc_nseg(input int width, input int seg_w);
      return (seg_w > 0) ? (width / seg_w) : 0;
   endfunction

   // SEG_W must be positive, no wider than the operand and divide it exactly.
   function automatic bit seg_cfg_ok(input int width, input int seg_w);
      return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Streaming bus of the pipelined adder: one valid/ready handshake on the
// operand side and one on the result side.
//   in_valid/in_ready   : operand handshake
//   a, b, c_in, sub     : operands, carry-in, subtract select
//   out_valid/out_ready : result handshake
//   sum, c_out, ovf     : result, carry out of MSB, signed overflow
// master = producer of operands / consumer of results, slave = the adder.
// -----------------------------------------------------------------------------
interface pipelined_adder_if
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             ovf;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf
   );

endinterface

// File: rtl/pipelined_adder_seg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_seg
// One pipeline stage of the segmented adder. Adds segment K of the operands
// plus the incoming carry, merges the SEG_W-bit partial sum into the
// accumulated result and registers it together with the carry, the full
// operands (upper segments still to be added) and the two sign bits.
//   clk, reset          : clock, asynchronous active-low reset
//   stage_ready         : this stage may load (empty or downstream ready)
//   up_valid            : upstream stage (or bus input) holds a transaction
//   up_psum .. up_b_msb : upstream payload
//   valid               : this stage holds a transaction
//   psum .. b_msb       : registered payload
// -----------------------------------------------------------------------------
module pipelined_adder_seg
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG_W = DEF_SEG_W,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stage_ready,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_psum,
   input  logic             up_carry,
   input  logic [WIDTH-1:0] up_a,
   input  logic [WIDTH-1:0] up_b,
   input  logic             up_a_msb,
   input  logic             up_b_msb,
   output logic             valid,
   output logic [WIDTH-1:0] psum,
   output logic             carry,
   output logic [WIDTH-1:0] a_q,
   output logic [WIDTH-1:0] b_q,
   output logic             a_msb,
   output logic             b_msb
);

   localparam int LSB = K * SEG_W;

   typedef struct packed {
      logic [WIDTH-1:0] psum;
      logic             carry;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             a_msb;
      logic             b_msb;
   } payload_t;

   function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] x,
                                              input logic [SEG_W-1:0] y,
                                              input logic             ci);
      return {1'b0, x} + {1'b0, y} + {{SEG_W{1'b0}}, ci};
   endfunction

   logic [SEG_W:0] seg_res;
   payload_t       nxt;
   payload_t       pl_q;
   logic           vld_q;

   always_comb begin
      seg_res   = seg_add(up_a[LSB +: SEG_W], up_b[LSB +: SEG_W], up_carry);
      // Segments at and above K are still zero in up_psum, so OR-ing the new
      // segment in is the same as a part-select write.
      nxt.psum  = up_psum | (WIDTH'(seg_res[SEG_W-1:0]) << LSB);
      nxt.carry = seg_res[SEG_W];
      nxt.a     = up_a;
      nxt.b     = up_b;
      nxt.a_msb = up_a_msb;
      nxt.b_msb = up_b_msb;
   end

   // ---- stage K register boundary ----
   // Payload only loads with a real transaction so a consumed result stays
   // visible until the next one arrives; a bubble only clears the valid bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q <= 1'b0;
         pl_q  <= '0;
      end else if (stage_ready) begin
         vld_q <= up_valid;
         if (up_valid) begin
            pl_q <= nxt;
         end
      end
   end

   assign valid = vld_q;
   assign psum  = pl_q.psum;
   assign carry = pl_q.carry;
   assign a_q   = pl_q.a;
   assign b_q   = pl_q.b;
   assign a_msb = pl_q.a_msb;
   assign b_msb = pl_q.b_msb;

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit add/subtract built as a carry-ripple pipeline of NSEG = WIDTH/SEG_W
// stages, SEG_W bits per stage, with elastic valid/ready flow control.
// One result per cycle, latency NSEG, capacity NSEG transactions.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : pipelined_adder_if.slave (operands in, results out)
// Subtract is A + ~B + 1; c_out = 1 then means "no borrow".
// -----------------------------------------------------------------------------
module pipelined_adder
   import pipelined_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SEG_W  = DEF_SEG_W,
   parameter int SUB_EN = 1
) (
   input  logic                clk,
   input  logic                reset,
   pipelined_adder_if.slave    bus
);

   localparam int NSEG = calc_nseg(WIDTH, SEG_W);

   if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
      $error("pipelined_adder: SEG_W=%0d must divide WIDTH=%0d", SEG_W, WIDTH);
   end

   // Index 0 is the bus input; index k+1 is the output of stage k.
   logic [NSEG:0]    vld;
   logic [NSEG:0]    rdy;
   logic [WIDTH-1:0] psum_s  [NSEG+1];
   logic             carry_s [NSEG+1];
   logic [WIDTH-1:0] a_s     [NSEG+1];
   logic [WIDTH-1:0] b_s     [NSEG+1];
   logic             a_msb_s [NSEG+1];
   logic             b_msb_s [NSEG+1];

   logic             sub_eff;

   if (SUB_EN != 0) begin : g_sub
      assign sub_eff = bus.sub;
   end else begin : g_no_sub
      logic unused_sub;
      assign sub_eff    = 1'b0;
      assign unused_sub = bus.sub;
   end

   assign vld[0]     = bus.in_valid;
   assign psum_s[0]  = '0;
   assign carry_s[0] = sub_eff ? 1'b1 : bus.c_in;
   assign a_s[0]     = bus.a;
   assign b_s[0]     = sub_eff ? ~bus.b : bus.b;
   assign a_msb_s[0] = bus.a[WIDTH-1];
   assign b_msb_s[0] = b_s[0][WIDTH-1];

   // ready_k = !valid_k || ready_{k+1}; a full stage can still load when the
   // one after it drains this cycle, so a full pipe streams without bubbles.
   always_comb begin
      rdy       = '0;
      rdy[NSEG] = bus.out_ready;
      for (int k = NSEG - 1; k >= 0; k--) begin
         rdy[k] = !vld[k+1] || rdy[k+1];
      end
   end

   for (genvar k = 0; k < NSEG; k++) begin : g_stage
      pipelined_adder_seg #(
         .WIDTH (WIDTH),
         .SEG_W (SEG_W),
         .K     (k)
      ) u_seg (
         .clk         (clk),
         .reset       (reset),
         .stage_ready (rdy[k]),
         .up_valid    (vld[k]),
         .up_psum     (psum_s[k]),
         .up_carry    (carry_s[k]),
         .up_a        (a_s[k]),
         .up_b        (b_s[k]),
         .up_a_msb    (a_msb_s[k]),
         .up_b_msb    (b_msb_s[k]),
         .valid       (vld[k+1]),
         .psum        (psum_s[k+1]),
         .carry       (carry_s[k+1]),
         .a_q         (a_s[k+1]),
         .b_q         (b_s[k+1]),
         .a_msb       (a_msb_s[k+1]),
         .b_msb       (b_msb_s[k+1])
      );
   end

   // Operands leaving the last stage have been fully consumed.
   logic unused_ops;
   assign unused_ops = ^{a_s[NSEG], b_s[NSEG]};

   assign bus.in_ready  = rdy[0];
   assign bus.out_valid = vld[NSEG];
   assign bus.sum       = psum_s[NSEG];
   assign bus.c_out     = carry_s[NSEG];
   // Overflow: operands share a sign and the result sign differs from it.
   assign bus.ovf       = (a_msb_s[NSEG] == b_msb_s[NSEG]) &&
                          (psum_s[NSEG][WIDTH-1] != a_msb_s[NSEG]);

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Directed bench for pipelined_adder at WIDTH=32, SEG_W=8 (latency 4).
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

   localparam int W   = 32;
   localparam int LAT = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(W)) bif ();

   pipelined_adder #(
      .WIDTH  (W),
      .SEG_W  (8),
      .SUB_EN (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        c_in;
      logic        sub;
      logic [31:0] sum;
      logic        c_out;
      logic        ovf;
   } vec_t;

   vec_t vt[10];

   function automatic vec_t mk(input string nm, input logic [31:0] a, input logic [31:0] b,
                               input logic ci, input logic sb, input logic [31:0] s,
                               input logic co, input logic ov);
      vec_t v;
      v.name = nm; v.a = a; v.b = b; v.c_in = ci; v.sub = sb;
      v.sum = s; v.c_out = co; v.ovf = ov;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %s", name, what);
   endtask

   // One isolated transaction into an empty pipe, with latency measurement.
   task automatic apply_one(input vec_t v);
      int cyc;
      @(negedge clk);
      bif.in_valid  = 1'b1;
      bif.a         = v.a;
      bif.b         = v.b;
      bif.c_in      = v.c_in;
      bif.sub       = v.sub;
      bif.out_ready = 1'b1;
      #1;
      check({v.name, " in_ready"}, 64'(bif.in_ready), 64'd1);
      @(negedge clk);
      bif.in_valid = 1'b0;
      cyc = 1;
      while (!bif.out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({v.name, " latency"}, 64'(cyc), 64'(LAT));
      check({v.name, " sum"},     64'(bif.sum),   64'(v.sum));
      check({v.name, " c_out"},   64'(bif.c_out), 64'(v.c_out));
      check({v.name, " ovf"},     64'(bif.ovf),   64'(v.ovf));
   endtask

   // Streaming of n adds a=a0+i, b=bk*i, c_in=cin; out_ready low on cycles
   // [stall_lo, stall_hi). Results are checked in order against a queue.
   task automatic stream(input string tag, input int n, input int stall_lo, input int stall_hi,
                         input logic [31:0] a0, input logic [31:0] bk, input logic cin,
                         input bit check_timing);
      logic [33:0] expq[$];
      logic [33:0] e;
      logic [32:0] s;
      logic [31:0] held_sum;
      logic        held;
      int          sent, got, cyc, first_acc, first_out, last_out, extra;
      sent = 0; got = 0; cyc = 0; extra = 0;
      first_acc = -1; first_out = -1; last_out = -1;
      held = 1'b0; held_sum = '0;
      while (got < n && cyc < 200) begin
         @(negedge clk);
         bif.out_ready = !(cyc >= stall_lo && cyc < stall_hi);
         bif.in_valid  = (sent < n);
         bif.a         = a0 + 32'(sent);
         bif.b         = bk * 32'(sent);
         bif.c_in      = cin;
         bif.sub       = 1'b0;
         #1;
         if (held) begin
            check({tag, " stall out_valid"}, 64'(bif.out_valid), 64'd1);
            check({tag, " stall sum hold"},  64'(bif.sum),       64'(held_sum));
         end
         if (cyc >= stall_lo + LAT && cyc < stall_hi)
            check({tag, " full in_ready"}, 64'(bif.in_ready), 64'd0);
         if (stall_hi > stall_lo && cyc == stall_hi)
            check({tag, " release in_ready"}, 64'(bif.in_ready), 64'd1);
         if (bif.in_valid && bif.in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            s = {1'b0, bif.a} + {1'b0, bif.b} + 33'(cin);
            expq.push_back({(bif.a[31] == bif.b[31]) && (s[31] != bif.a[31]), s});
            sent++;
         end
         if (stall_hi > stall_lo && cyc == stall_hi - 1)
            check({tag, " accepted while stalled"}, 64'(sent), 64'(LAT));
         if (bif.out_valid && bif.out_ready) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (expq.size() == 0) begin
               fail_now({tag, " result"}, "output with no outstanding transaction");
            end else begin
               e = expq.pop_front();
               check($sformatf("%s result %0d", tag, got), 64'({bif.ovf, bif.c_out, bif.sum}), 64'(e));
            end
            got++;
         end
         held     = bif.out_valid && !bif.out_ready;
         held_sum = bif.sum;
         cyc++;
      end
      bif.in_valid = 1'b0;
      check({tag, " results received"}, 64'(got), 64'(n));
      check({tag, " queue drained"}, 64'(expq.size()), 64'd0);
      if (check_timing) begin
         check({tag, " first latency"}, 64'(first_out - first_acc), 64'(LAT));
         check({tag, " consecutive"},   64'(last_out - first_out),  64'(n - 1));
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bif.out_valid) extra++;
      end
      check({tag, " no duplicates"}, 64'(extra), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int stale;
      vt[0] = mk("ripple",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      vt[1] = mk("sub 5-7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      vt[2] = mk("sub 7-5",    32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
      vt[3] = mk("ovf pos",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      vt[4] = mk("ovf neg",    32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      vt[5] = mk("cin add",    32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);
      vt[6] = mk("sub ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      vt[7] = mk("sub zero",   32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      vt[8] = mk("mid carry",  32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
      vt[9] = mk("cin ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

      bif.in_valid  = 1'b0;
      bif.a         = '0;
      bif.b         = '0;
      bif.c_in      = 1'b0;
      bif.sub       = 1'b0;
      bif.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("reset out_valid", 64'(bif.out_valid), 64'd0);
      check("reset sum",       64'(bif.sum),       64'd0);
      check("reset c_out",     64'(bif.c_out),     64'd0);
      check("reset ovf",       64'(bif.ovf),       64'd0);
      reset = 1'b1;
      #1;
      check("post-reset in_ready", 64'(bif.in_ready), 64'd1);

      foreach (vt[i]) apply_one(vt[i]);

      stream("stream", 10, 0, 0, 32'd0, 32'd1, 1'b1, 1'b1);
      stream("backpressure", 8, 0, 6, 32'd100, 32'd3, 1'b0, 1'b0);

      // Three transactions in flight, oldest sitting at the output.
      @(negedge clk);
      bif.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bif.in_valid = 1'b1;
         bif.a        = 32'h0000_1000 + 32'(i);
         bif.b        = 32'h0000_0010;
         bif.c_in     = 1'b0;
         bif.sub      = 1'b0;
         @(negedge clk);
      end
      bif.in_valid = 1'b0;
      @(negedge clk);
      check("pre-reset out_valid", 64'(bif.out_valid), 64'd1);
      check("pre-reset sum",       64'(bif.sum),       64'h1010);
      #2 reset = 1'b0;
      #1;
      check("async reset out_valid", 64'(bif.out_valid), 64'd0);
      check("async reset sum",       64'(bif.sum),       64'd0);
      check("async reset c_out",     64'(bif.c_out),     64'd0);
      check("async reset in_ready",  64'(bif.in_ready),  64'd1);
      @(negedge clk);
      reset         = 1'b1;
      bif.out_ready = 1'b1;
      stale = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bif.out_valid) stale++;
      end
      check("no stale after reset", 64'(stale), 64'd0);
      apply_one(mk("after reset", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
